jamma_input_scanner: RTL and testbench

- Time-multiplexed scan controller for the 16 JAMMA switch inputs behind the 16:1 one-bit input mux.
- Drives the mux select and samples the muxed bit after a settle delay.
- Debounces each channel and holds a stable 16-bit input image.
- Queues level-change events in a 4-entry FIFO for the CPU/game-logic side, with a valid/ack handshake.

---
 rtl/jamma_input_scanner.sv | 134 +++++++++++++
 tb/tb_jamma_input_scanner.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jamma_input_scanner.sv
// Walks the 16:1 JAMMA input mux, debounces every switch into a stable image
// and queues level-change events in a 4-deep FIFO for the game logic.
module jamma_input_scanner #(
    parameter int SETTLE    = 4,
    parameter int DEB_COUNT = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ena,
    output logic [3:0]  sel,
    input  logic        mux_in,
    output logic [15:0] state,
    output logic        scan_done,
    output logic        evt_valid,
    output logic [4:0]  evt_code,
    input  logic        evt_ack,
    output logic        overflow,
    input  logic        ovf_clr
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE} fsm_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [3:0] DEB_LAST    = 4'(DEB_COUNT - 1);

    fsm_t       fsm;
    logic [3:0] settle_cnt;
    logic [3:0] deb [16];

    logic       disagree;
    logic       flip;
    logic       full;
    logic       pop;
    logic       do_push;
    logic       drop;

    logic [4:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    assign evt_valid = (count != 3'd0);
    assign evt_code  = evt_valid ? fifo_mem[rd_ptr] : 5'd0;

    // NOTE: every signal gets a value on every path here, so no latch is inferred.
    always_comb begin
        disagree = (mux_in != state[sel]);
        flip     = (fsm == ST_SAMPLE) && disagree && (deb[sel] == DEB_LAST);
        full     = (count == 3'd4);
        pop      = evt_valid && evt_ack;
        do_push  = flip && (!full || pop);
        drop     = flip && full && !pop;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fsm        <= ST_IDLE;
            sel        <= 4'd0;
            settle_cnt <= 4'd0;
            state      <= 16'd0;
            scan_done  <= 1'b0;
            for (int i = 0; i < 16; i++) deb[i] <= 4'd0;
        end else begin
            scan_done <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    sel <= 4'd0;
                    if (ena) begin
                        fsm        <= ST_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (!ena) begin
                        fsm <= ST_IDLE;
                        sel <= 4'd0;
                    end else if (settle_cnt == 4'd0) begin
                        fsm <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (!disagree) begin
                        deb[sel] <= 4'd0;
                    end else if (flip) begin
                        state[sel] <= mux_in;
                        deb[sel]   <= 4'd0;
                    end else begin
                        deb[sel] <= deb[sel] + 4'd1;
                    end
                    scan_done <= (sel == 4'd15);
                    if (ena) begin
                        fsm        <= ST_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        sel        <= sel + 4'd1;
                    end else begin
                        fsm <= ST_IDLE;
                        sel <= 4'd0;
                    end
                end
                default: begin
                    fsm <= ST_IDLE;
                    sel <= 4'd0;
                end
            endcase
        end
    end

    // NOTE: the event storage carries no reset; evt_code is masked while empty,
    // so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr] <= {mux_in, sel};
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'd0, do_push} - {2'd0, pop};
            // A new drop takes priority over a clear in the same cycle.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Self-checking bench for jamma_input_scanner: directed vector table, hand-built
// corner sequences and a randomized run against a behavioural scan model.
module tb_jamma_input_scanner;

    localparam int P_SETTLE = 4;
    localparam int P_DEB    = 3;

    logic        clk;
    logic        clrn;
    logic        ena;
    logic [3:0]  sel;
    logic        mux_in;
    logic [15:0] state;
    logic        scan_done;
    logic        evt_valid;
    logic [4:0]  evt_code;
    logic        evt_ack;
    logic        overflow;
    logic        ovf_clr;
    logic [15:0] pins;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    jamma_input_scanner #(.SETTLE(P_SETTLE), .DEB_COUNT(P_DEB)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ena       (ena),
        .sel       (sel),
        .mux_in    (mux_in),
        .state     (state),
        .scan_done (scan_done),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ack   (evt_ack),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    // External 16:1 mux in front of the scanner.
    assign mux_in = pins[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a channel slot needs SETTLE+1 enabled edges, then one sample edge.
    int          m_prep;
    int          m_ch;
    logic [15:0] m_state;
    int          m_deb [16];
    logic [4:0]  m_q [$];
    logic        m_ovf;
    logic        m_done;

    function automatic void model_reset();
        m_prep  = 0;
        m_ch    = 0;
        m_state = 16'd0;
        for (int i = 0; i < 16; i++) m_deb[i] = 0;
        m_q.delete();
        m_ovf   = 1'b0;
        m_done  = 1'b0;
    endfunction

    function automatic void model_edge();
        logic       do_pop;
        logic       do_push;
        logic       dropped;
        logic       s;
        logic [4:0] ev;
        do_pop  = (m_q.size() != 0) && evt_ack;
        do_push = 1'b0;
        dropped = 1'b0;
        ev      = 5'd0;
        m_done  = 1'b0;
        if (m_prep == P_SETTLE + 1) begin
            s = pins[m_ch];
            if (s == m_state[m_ch]) begin
                m_deb[m_ch] = 0;
            end else if (m_deb[m_ch] + 1 == P_DEB) begin
                m_state[m_ch] = s;
                m_deb[m_ch]   = 0;
                do_push       = 1'b1;
                ev            = {s, 4'(m_ch)};
            end else begin
                m_deb[m_ch] = m_deb[m_ch] + 1;
            end
            m_done = (m_ch == 15);
            if (ena) begin
                m_ch   = (m_ch + 1) % 16;
                m_prep = 1;
            end else begin
                m_ch   = 0;
                m_prep = 0;
            end
        end else if (ena) begin
            m_prep = m_prep + 1;
        end else begin
            m_prep = 0;
            m_ch   = 0;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < 4) m_q.push_back(ev);
            else dropped = 1'b1;
        end
        if (dropped)      m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endfunction

    function automatic logic [31:0] model_vec();
        logic [4:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 5'd0;
        return {4'd0, 4'(m_ch), m_state, m_done, (m_q.size() != 0), head, m_ovf};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {4'd0, sel, state, scan_done, evt_valid, evt_code, overflow};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then releases.
    task automatic do_reset();
        #2 clrn = 1'b0;
        model_reset();
        #1;
        check("rst_sel", sel, 0);
        check("rst_state", state, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", scan_done, 0);
        #2 clrn = 1'b1;
        cyc = 0;
    endtask

    typedef struct {
        logic [15:0] pins;
        logic        ack;
        int          cycles;
        logic [15:0] exp_state;
        logic        exp_valid;
        logic [4:0]  exp_code;
    } vec_t;

    vec_t vecs [8];
    int   k;
    int   off_cnt;
    int   ack_div;

    initial begin
        clrn    = 1'b0;
        ena     = 1'b0;
        evt_ack = 1'b0;
        ovf_clr = 1'b0;
        pins    = 16'd0;
        model_reset();

        vecs[0] = '{16'h0020, 1'b0, 190, 16'h0000, 1'b0, 5'h00};
        vecs[1] = '{16'h0020, 1'b0,   1, 16'h0020, 1'b1, 5'h15};
        vecs[2] = '{16'h0020, 1'b1,   1, 16'h0020, 1'b0, 5'h00};
        vecs[3] = '{16'h0220, 1'b0, 110, 16'h0020, 1'b0, 5'h00};
        vecs[4] = '{16'h0020, 1'b0, 100, 16'h0020, 1'b0, 5'h00};
        vecs[5] = '{16'h0220, 1'b0, 208, 16'h0020, 1'b0, 5'h00};
        vecs[6] = '{16'h0220, 1'b0,   1, 16'h0220, 1'b1, 5'h19};
        vecs[7] = '{16'h0220, 1'b1,   1, 16'h0220, 1'b0, 5'h00};

        // Channel 5 debounce, then channel 9 glitch and stable change.
        #1;
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pins    = vecs[i].pins;
            evt_ack = vecs[i].ack;
            repeat (vecs[i].cycles) tick();
            evt_ack = 1'b0;
            check("vec_state", state, vecs[i].exp_state);
            check("vec_valid", evt_valid, vecs[i].exp_valid);
            check("vec_code", evt_code, vecs[i].exp_code);
        end

        // ena dropped in channel 7 settle; debounce progress must survive.
        do_reset();
        pins = 16'h0008;
        ena  = 1'b1;
        run_to(38);
        check("drop_sel_before", sel, 7);
        ena = 1'b0;
        tick();
        check("drop_sel_after", sel, 0);
        check("drop_state", state, 0);
        repeat (5) tick();
        k   = cyc;
        ena = 1'b1;
        run_to(k + 5);
        check("restart_sel0", sel, 0);
        tick();
        check("restart_sel1", sel, 1);
        run_to(k + 80);
        check("done_low_before", scan_done, 0);
        tick();
        check("done_pulse1", scan_done, 1);
        tick();
        check("done_low_after", scan_done, 0);
        run_to(k + 100);
        check("deb_kept_pre", state, 16'h0000);
        tick();
        check("deb_kept_flip", state, 16'h0008);
        run_to(k + 160);
        check("done_gap", scan_done, 0);
        tick();
        check("done_pulse2", scan_done, 1);

        // Six channels flip with no ack: four queued, two dropped.
        do_reset();
        pins = 16'h003F;
        ena  = 1'b1;
        run_to(191);
        check("ovf_state", state, 16'h003F);
        check("ovf_flag", overflow, 1);
        check("ovf_valid", evt_valid, 1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_pop_code", evt_code, 32'h10 + i);
            evt_ack = 1'b1;
            tick();
        end
        evt_ack = 1'b0;
        check("ovf_drained", evt_valid, 0);
        pins    = 16'h07FF;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        run_to(375);
        check("full_head", evt_code, 5'h16);
        check("full_ovf_pre", overflow, 0);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        check("pushpop_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            check("pushpop_code", evt_code, 32'h17 + i);
            evt_ack = 1'b1;
            tick();
        end
        evt_ack = 1'b0;
        check("pushpop_empty", evt_valid, 0);

        // Reset mid-settle with two events queued.
        do_reset();
        pins = 16'h0003;
        ena  = 1'b1;
        run_to(173);
        check("pre_rst_valid", evt_valid, 1);
        check("pre_rst_sel", sel, 2);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_sel0", sel, 0);
        end
        tick();
        check("post_rst_sel1", sel, 1);

        // Randomized run: rare acks first to reach overflow, then frequent acks.
        do_reset();
        pins    = 16'h0000;
        ena     = 1'b1;
        off_cnt = 0;
        for (int phase = 0; phase < 2; phase++) begin
            ack_div = (phase == 0) ? 150 : 4;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 29) == 0) pins[$urandom_range(0, 15)] ^= 1'b1;
                if (off_cnt > 0) begin
                    ena = 1'b0;
                    off_cnt--;
                end else begin
                    ena = 1'b1;
                    if ($urandom_range(0, 399) == 0) off_cnt = $urandom_range(1, 12);
                end
                evt_ack = ($urandom_range(0, ack_div - 1) == 0);
                ovf_clr = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        evt_ack = 1'b0;
        ovf_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
